// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: multi-cycle MSB-first magnitude compare, STEP bits per clock, early exit.
// Optional TRISTATE_OUT_EN adds port oe that tri-states gt/eq/lt.
module serial_mag_comparator #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = $clog2(WIDTH/STEP)+1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef TRISTATE_OUT_EN
    input  logic             oe,
`endif
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH/STEP-1);
    state_t state, state_n;
    logic [WIDTH-1:0] sa, sb, sa_n, sb_n, flip;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [STEP-1:0] ca, cb;
    logic done_n, gt_r, eq_r, lt_r, gt_n, eq_n, lt_n;
    // flipping both sign bits maps two's-complement order onto unsigned order
    assign flip = {signed_en, {(WIDTH-1){1'b0}}};
    assign ca = sa[WIDTH-1 -: STEP];
    assign cb = sb[WIDTH-1 -: STEP];
    assign busy = state == RUN;
    always_comb begin
        state_n = state;
        sa_n = sa;
        sb_n = sb;
        cnt_n = cnt;
        done_n = 1'b0;
        gt_n = gt_r;
        eq_n = eq_r;
        lt_n = lt_r;
        if (state == IDLE) begin
            if (start) begin
                sa_n = a ^ flip;
                sb_n = b ^ flip;
                cnt_n = '0;
                gt_n = 1'b0;
                eq_n = 1'b0;
                lt_n = 1'b0;
                state_n = RUN;
            end
        end else if (ca != cb) begin
            gt_n = ca > cb;
            lt_n = ca < cb;
            done_n = 1'b1;
            state_n = IDLE;
        end else if (cnt == LAST) begin
            eq_n = 1'b1;
            done_n = 1'b1;
            state_n = IDLE;
        end else begin
            sa_n = sa << STEP;
            sb_n = sb << STEP;
            cnt_n = cnt + CNT_W'(1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa <= '0;
            sb <= '0;
            cnt <= '0;
            done <= 1'b0;
            gt_r <= 1'b0;
            eq_r <= 1'b0;
            lt_r <= 1'b0;
        end else begin
            state <= state_n;
            sa <= sa_n;
            sb <= sb_n;
            cnt <= cnt_n;
            done <= done_n;
            gt_r <= gt_n;
            eq_r <= eq_n;
            lt_r <= lt_n;
        end
    end
`ifdef TRISTATE_OUT_EN
    assign gt = oe ? gt_r : 1'bz;
    assign eq = oe ? eq_r : 1'bz;
    assign lt = oe ? lt_r : 1'bz;
`else
    assign gt = gt_r;
    assign eq = eq_r;
    assign lt = lt_r;
`endif
endmodule
